// File: rtl/border_draw_ctrl.sv
// Border rectangle pixel generator for a VGA adapter: press-and-release start, one pixel per step.
// Optional macro BORDER_SIDES_EN adds the LEFT/RIGHT vertical edges to the top/bottom lines.
module border_draw_ctrl #(
  parameter int         X_LEFT   = 15,
  parameter int         X_RIGHT  = 140,
  parameter int         Y_TOP    = 20,
  parameter int         Y_BOTTOM = 105,
  parameter logic [2:0] COLOUR   = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       step,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] XL  = 8'(X_LEFT);
  localparam logic [7:0] XR  = 8'(X_RIGHT);
  localparam logic [6:0] YT  = 7'(Y_TOP);
  localparam logic [6:0] YB  = 7'(Y_BOTTOM);
`ifdef BORDER_SIDES_EN
  // Side edges skip the corner rows, which the horizontal lines already own.
  localparam logic [6:0] YS0 = 7'(Y_TOP + 1);
  localparam logic [6:0] YS1 = 7'(Y_BOTTOM - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    TOP,
    BOTTOM,
`ifdef BORDER_SIDES_EN
    LEFT,
    RIGHT,
`endif
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic       drawing;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= XL;
      y_q     <= YT;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    drawing = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) state_d = ARM;
      end
      ARM: begin
        if (!go) begin
          state_d = TOP;
          x_d     = XL;
          y_d     = YT;
        end
      end
      TOP: begin
        drawing = 1'b1;
        if (step) begin
          if (x_q == XR) begin
            state_d = BOTTOM;
            x_d     = XL;
            y_d     = YB;
          end else begin
            x_d = x_q + 8'd1;
          end
        end
      end
      BOTTOM: begin
        drawing = 1'b1;
        if (step) begin
          if (x_q == XR) begin
`ifdef BORDER_SIDES_EN
            state_d = LEFT;
            x_d     = XL;
            y_d     = YS0;
`else
            state_d = DONE;
`endif
          end else begin
            x_d = x_q + 8'd1;
          end
        end
      end
`ifdef BORDER_SIDES_EN
      LEFT: begin
        drawing = 1'b1;
        if (step) begin
          if (y_q == YS1) begin
            state_d = RIGHT;
            x_d     = XR;
            y_d     = YS0;
          end else begin
            y_d = y_q + 7'd1;
          end
        end
      end
      RIGHT: begin
        drawing = 1'b1;
        if (step) begin
          if (y_q == YS1) state_d = DONE;
          else            y_d     = y_q + 7'd1;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
        x_d     = XL;
        y_d     = YT;
      end
      default: begin
        state_d = IDLE;
        x_d     = XL;
        y_d     = YT;
      end
    endcase
  end

  // A reset cycle never writes a pixel, even mid-sweep.
  assign plot   = step & drawing & ~reset;
  assign busy   = (state_q != IDLE) && (state_q != ARM);
  assign done   = (state_q == DONE);
  assign x      = x_q;
  assign y      = y_q;
  assign colour = COLOUR;

endmodule

// File: tb/tb_border_draw_ctrl.sv
// Directed bench for border_draw_ctrl: cycle vector table plus full-sweep, pacing, reset and stall sequences.
module tb_border_draw_ctrl;

  localparam int XL = 15;
  localparam int XR = 140;
  localparam int YT = 20;
  localparam int YB = 105;

  logic       clk, reset, go, step;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;

  int total = 0;
  int bad   = 0;

  int ex_q[$];
  int ey_q[$];

  border_draw_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .go     (go),
    .step   (step),
    .x      (x),
    .y      (y),
    .colour (colour),
    .plot   (plot),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       go;
    logic       step;
    logic       chk;
    logic [2:0] pbd;
    logic [7:0] ex;
    logic [6:0] ey;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic g, input logic s, input logic c,
                              input logic [2:0] pbd, input int ex, input int ey);
    vec_t v;
    v.rst = r; v.go = g; v.step = s; v.chk = c;
    v.pbd = pbd; v.ex = 8'(ex); v.ey = 7'(ey);
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance through one rising edge and land on the following falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; go = 1'b0; step = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic run_seq(input int smod, input bit gtog, input string tag);
    int rx[$];
    int ry[$];
    int mism, viol, dcnt, n, prevx, prevy;
    bit havep, prev_step, fin;
    rx.delete(); ry.delete();
    mism = 0; viol = 0; dcnt = 0; havep = 0; prev_step = 1'b1; fin = 0;
    prevx = 0; prevy = 0;
    go = 1'b1; step = 1'b1;
    cyc();
    go = 1'b0;
    cyc();
    for (int k = 0; k < 6000; k++) begin
      step = ((k % smod) == 0);
      if (gtog) go = 1'($urandom_range(0, 1));
      #1;
      if (plot) begin
        rx.push_back(int'(x));
        ry.push_back(int'(y));
        if (!step) viol++;
      end
      if (busy && !step && !prev_step && havep && (int'(x) != prevx || int'(y) != prevy)) viol++;
      prevx = int'(x); prevy = int'(y); havep = 1; prev_step = step;
      if (done) begin
        dcnt++;
        if (plot) viol++;
        fin = 1;
        cyc();
        break;
      end
      cyc();
    end
    check({tag, "_finished"}, int'(fin), 1);
    go = 1'b0; step = 1'b1;
    #1;
    check({tag, "_done_width"}, int'(done), 0);
    check({tag, "_busy_after"}, int'(busy), 0);
    n = (rx.size() < ex_q.size()) ? rx.size() : ex_q.size();
    for (int i = 0; i < n; i++)
      if (rx[i] != ex_q[i] || ry[i] != ey_q[i]) mism++;
    check({tag, "_plot_count"}, rx.size(), ex_q.size());
    check({tag, "_pixel_mismatches"}, mism, 0);
    check({tag, "_done_pulses"}, dcnt, 1);
    check({tag, "_pacing_violations"}, viol, 0);
    cyc();
  endtask

  initial begin
    vec_t tbl[11];
    int   viol;
    bit   found;

    for (int xi = XL; xi <= XR; xi++) begin ex_q.push_back(xi); ey_q.push_back(YT); end
    for (int xi = XL; xi <= XR; xi++) begin ex_q.push_back(xi); ey_q.push_back(YB); end
`ifdef BORDER_SIDES_EN
    for (int yi = YT + 1; yi <= YB - 1; yi++) begin ex_q.push_back(XL); ey_q.push_back(yi); end
    for (int yi = YT + 1; yi <= YB - 1; yi++) begin ex_q.push_back(XR); ey_q.push_back(yi); end
`endif

    // {reset, go, step, check, {plot,busy,done}, x, y} as seen before each rising edge
    tbl[0]  = mk(1, 0, 1, 0, 3'b000, XL, YT);
    tbl[1]  = mk(0, 0, 1, 1, 3'b000, XL, YT);
    tbl[2]  = mk(0, 1, 1, 1, 3'b000, XL, YT);
    tbl[3]  = mk(0, 1, 1, 1, 3'b000, XL, YT);
    tbl[4]  = mk(0, 0, 1, 1, 3'b000, XL, YT);
    tbl[5]  = mk(0, 0, 1, 1, 3'b110, 15, YT);
    tbl[6]  = mk(0, 0, 0, 1, 3'b010, 16, YT);
    tbl[7]  = mk(0, 1, 1, 1, 3'b110, 16, YT);
    tbl[8]  = mk(0, 0, 1, 1, 3'b110, 17, YT);
    tbl[9]  = mk(1, 0, 1, 1, 3'b010, 18, YT);
    tbl[10] = mk(0, 0, 1, 1, 3'b000, XL, YT);

    reset = 1'b1; go = 1'b0; step = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      reset = tbl[i].rst; go = tbl[i].go; step = tbl[i].step;
      #1;
      if (tbl[i].chk) begin
        check($sformatf("vec%0d_pbd", i), int'({plot, busy, done}), int'(tbl[i].pbd));
        check($sformatf("vec%0d_xy", i), int'({x, y}), int'({tbl[i].ex, tbl[i].ey}));
      end
      check($sformatf("vec%0d_colour", i), int'(colour), 7);
      cyc();
    end
    reset = 1'b0; go = 1'b0; step = 1'b1;

    run_seq(1, 1'b0, "full");
    run_seq(4, 1'b0, "step4");

    // Long button hold: nothing may be drawn until release.
    viol = 0;
    go = 1'b1; step = 1'b1;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (plot || busy) viol++;
      cyc();
    end
    check("hold_no_activity", viol, 0);
    go = 1'b0;
    cyc();
    #1;
    check("hold_release_busy", int'(busy), 1);
    check("hold_release_xy", int'({plot, x, y}), int'({1'b1, 8'(XL), 7'(YT)}));
    do_reset();

    run_seq(1, 1'b1, "gotoggle");

    // Reset in the middle of the top sweep.
    go = 1'b1; step = 1'b1;
    cyc();
    go = 1'b0;
    cyc();
    found = 0;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (x == 8'd60) begin found = 1; break; end
      cyc();
    end
    check("reset_reach_x60", int'(found), 1);
    reset = 1'b1;
    #1;
    check("reset_cycle_plot", int'(plot), 0);
    cyc();
    reset = 1'b0;
    #1;
    check("after_reset_pbd", int'({plot, busy, done}), 0);
    check("after_reset_xy", int'({x, y}), int'({8'(XL), 7'(YT)}));
    go = 1'b1;
    cyc();
    go = 1'b0;
    cyc();
    #1;
    check("restart_first_pixel", int'({plot, busy, x, y}), int'({2'b11, 8'(XL), 7'(YT)}));
    do_reset();

    // Indefinite stall with step low right after entering TOP.
    step = 1'b0; go = 1'b1;
    cyc();
    go = 1'b0;
    cyc();
    viol = 0;
    for (int k = 0; k < 1000; k++) begin
      #1;
      if (!busy || plot || x != 8'(XL) || y != 7'(YT)) viol++;
      cyc();
    end
    check("stall_hold", viol, 0);
    step = 1'b1;
    #1;
    check("stall_resume_pixel", int'({plot, x, y}), int'({1'b1, 8'(XL), 7'(YT)}));
    cyc();
    #1;
    check("stall_resume_next", int'({plot, x, y}), int'({1'b1, 8'(XL + 1), 7'(YT)}));
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
